// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle for fifo_sync_param: producer/consumer side is master, FIFO is slave.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              err_clr;
  logic              w_en;
  logic [DATA_W-1:0] dwrite;
  logic              r_en;
  logic [DATA_W-1:0] dread;
  logic              dread_valid;
  logic              full_indicate;
  logic              empty_indicate;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, err_clr, w_en, dwrite, r_en,
    input  dread, dread_valid, full_indicate, empty_indicate, almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  flush, err_clr, w_en, dwrite, r_en,
    output dread, dread_valid, full_indicate, empty_indicate, almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered read data, occupancy flags, sticky errors and sync flush.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic               clk,
  input logic               reset,
  fifo_sync_param_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [PTR_W-1:0] CntFull = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AfLevel = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AeLevel = PTR_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dread_q, dread_d;
  logic              dread_valid_q, dread_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // Flush takes precedence: no data moves and no error is recorded that cycle.
  assign wr_acc = bus.w_en & ~full  & ~bus.flush;
  assign rd_acc = bus.r_en & ~empty & ~bus.flush;

  always_comb begin
    wp_d          = wp_q;
    rp_d          = rp_q;
    count_d       = count_q;
    dread_d       = dread_q;
    dread_valid_d = 1'b0;

    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wp_d = wp_q + PtrOne;
      end
      if (rd_acc) begin
        rp_d          = rp_q + PtrOne;
        dread_d       = mem_q[rp_q[ADDR_W-1:0]];
        dread_valid_d = 1'b1;
      end
      count_d = count_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);
    end

    // A new error in the same cycle as err_clr stays set.
    overflow_d  = (bus.w_en & full  & ~bus.flush) | (overflow_q  & ~bus.err_clr);
    underflow_d = (bus.r_en & empty & ~bus.flush) | (underflow_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      dread_q       <= '0;
      dread_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      dread_q       <= dread_d;
      dread_valid_q <= dread_valid_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage is not reset; valid data is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wp_q[ADDR_W-1:0]] <= bus.dwrite;
    end
  end

  assign bus.dread          = dread_q;
  assign bus.dread_valid    = dread_valid_q;
  assign bus.full_indicate  = full;
  assign bus.empty_indicate = empty;
  assign bus.almost_full    = (count_q >= AfLevel);
  assign bus.almost_empty   = (count_q <= AeLevel);
  assign bus.count          = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: queue-based reference model, directed then random traffic.
module tb_fifo_sync_param;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AF_LEVEL = 6;
  localparam int unsigned AE_LEVEL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: stored words, expected read-data stream, sticky errors.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_ov = 1'b0;
  bit                m_un = 1'b0;
  logic [DATA_W-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("full", 32'(bus.full_indicate), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus.empty_indicate), 32'(mq.size() == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AF_LEVEL));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= AE_LEVEL));
    chk("overflow", 32'(bus.overflow), 32'(m_ov));
    chk("underflow", 32'(bus.underflow), 32'(m_un));
  endtask

  // One clock of stimulus; returns at posedge+1 so callers may sample settled outputs.
  task automatic step(input bit w, input bit [DATA_W-1:0] d, input bit r,
                      input bit fl = 1'b0, input bit ec = 1'b0);
    bit is_full, is_empty, new_ov, new_un;
    bus.w_en    = w;
    bus.dwrite  = d;
    bus.r_en    = r;
    bus.flush   = fl;
    bus.err_clr = ec;
    @(negedge clk);
    check_status();
    is_full  = (mq.size() == DEPTH);
    is_empty = (mq.size() == 0);
    new_ov   = 1'b0;
    new_un   = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (r && !is_empty) exp_q.push_back(mq.pop_front());
      if (w && !is_full) mq.push_back(d);
      new_ov = w && is_full;
      new_un = r && is_empty;
    end
    m_ov = new_ov || (m_ov && !ec);
    m_un = new_un || (m_un && !ec);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.dwrite  = '0;
    reset       = 1'b1;
    mq.delete();
    exp_q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest expected word; otherwise dread must hold.
  always @(negedge clk) begin
    if (reset) begin
      last_rd = '0;
    end else if (bus.dread_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_valid: got dread_valid=1 with dread %0h expected no strobe",
                 bus.dread);
      end else begin
        last_rd = exp_q.pop_front();
        chk("dread", 32'(bus.dread), 32'(last_rd));
      end
    end else begin
      chk("dread_hold", 32'(bus.dread), 32'(last_rd));
    end
  end

  initial begin
    do_reset();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty_indicate), 32'd1);
    chk("rst_full", 32'(bus.full_indicate), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_valid", 32'(bus.dread_valid), 32'd0);
    chk("rst_dread", 32'(bus.dread), 32'd0);

    // Three writes then three reads
    step(1, 4'h9, 0);
    step(1, 4'hB, 0);
    step(1, 4'h3, 0);
    chk("t1_count3", 32'(bus.count), 32'd3);
    repeat (3) step(0, 4'h0, 1);
    chk("t1_count0", 32'(bus.count), 32'd0);
    chk("t1_empty", 32'(bus.empty_indicate), 32'd1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) step(1, 4'(i), 0);
    chk("t2_full", 32'(bus.full_indicate), 32'd1);
    chk("t2_count8", 32'(bus.count), 32'd8);
    step(1, 4'hF, 0);
    chk("t2_overflow", 32'(bus.overflow), 32'd1);
    chk("t2_count_stays", 32'(bus.count), 32'd8);
    repeat (9) step(0, 4'h0, 1);

    // Underflow on empty after reset, then clear
    do_reset();
    step(0, 4'h0, 1);
    chk("t3_underflow", 32'(bus.underflow), 32'd1);
    chk("t3_valid", 32'(bus.dread_valid), 32'd0);
    chk("t3_dread", 32'(bus.dread), 32'd0);
    step(0, 4'h0, 0, 0, 1);
    chk("t3_cleared", 32'(bus.underflow), 32'd0);

    // Steady count=4 with simultaneous traffic across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 4'(i), 0);
    for (int i = 4; i < 24; i++) step(1, 4'(i), 1);
    chk("t4_count4", 32'(bus.count), 32'd4);
    chk("t4_no_ov", 32'(bus.overflow), 32'd0);
    chk("t4_no_un", 32'(bus.underflow), 32'd0);

    // Simultaneous request at full and at empty
    for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 0);
    step(1, 4'hA, 1);
    chk("t5_count7", 32'(bus.count), 32'd7);
    chk("t5_overflow", 32'(bus.overflow), 32'd1);
    repeat (7) step(0, 4'h0, 1);
    step(1, 4'h6, 1);
    chk("t5_count1", 32'(bus.count), 32'd1);
    chk("t5_underflow", 32'(bus.underflow), 32'd1);

    // Flush beats a same-cycle write; then reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4'(i + 3), 0);
    step(1, 4'hE, 0, 1);
    chk("t6_flush_count", 32'(bus.count), 32'd0);
    chk("t6_flush_empty", 32'(bus.empty_indicate), 32'd1);
    chk("t6_flush_ov", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 4'(i + 1), 0);
    step(1, 4'h5, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty_indicate), 32'd1);
    chk("t6_rst_valid", 32'(bus.dread_valid), 32'd0);
    chk("t6_rst_dread", 32'(bus.dread), 32'd0);
    do_reset();

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int unsigned pw;
      pw = ((i / 100) % 2 == 1) ? 80 : 30;
      step($urandom_range(99) < pw, 4'($urandom), $urandom_range(99) < (100 - pw),
           $urandom_range(63) == 0, $urandom_range(15) == 0);
    end

    repeat (2) step(0, 4'h0, 0);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
